// File: rtl/cbx_param_cfg.sv
// X-channel connection block: IPIN muxes fed from left/right tracks, double-buffered selects.
// Build option CB_CFG_PARITY_EN adds port cfg_parity and an even-parity check on commit.
module cbx_param_cfg #(
  parameter int CHAN_W   = 20,
  parameter int NUM_IPIN = 6,
  parameter int MUX_SIZE = 10,
  parameter int SEL_W    = 4,
  parameter int STRIDE   = 3
) (
  input  logic                prog_clk,
  input  logic                prog_reset,
  input  logic [CHAN_W-1:0]   chanx_left_in,
  input  logic [CHAN_W-1:0]   chanx_right_in,
  output logic [CHAN_W-1:0]   chanx_left_out,
  output logic [CHAN_W-1:0]   chanx_right_out,
  output logic [NUM_IPIN-1:0] bottom_grid_pin,
  input  logic                ccff_head,
  input  logic                ccff_en,
  input  logic                cfg_commit,
  output logic                ccff_tail,
  output logic                cfg_full,
  output logic                cfg_ack,
  output logic                cfg_err
`ifdef CB_CFG_PARITY_EN
  ,
  input  logic                cfg_parity
`endif
);

  localparam int CHAIN_LEN = NUM_IPIN * SEL_W;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  function automatic logic even_parity(input logic [CHAIN_LEN-1:0] bits);
    return ^bits;
  endfunction

  logic [CHAIN_LEN-1:0] chain_r, chain_nxt_s;
  logic [CHAIN_LEN-1:0] active_r, active_nxt_s;
  logic [CNT_W-1:0]     bit_cnt_r, bit_cnt_nxt_s;
  logic                 ack_r, ack_nxt_s;
  logic                 err_r, err_nxt_s;
  logic                 full_s, parity_ok_s, shift_s, commit_ok_s, commit_bad_s;
  logic [NUM_IPIN-1:0][MUX_SIZE-1:0] mux_in_s;
  logic [NUM_IPIN-1:0]  pin_s;

  assign chanx_left_out  = chanx_right_in;
  assign chanx_right_out = chanx_left_in;

  assign full_s = (bit_cnt_r == CNT_FULL);

`ifdef CB_CFG_PARITY_EN
  assign parity_ok_s = (even_parity(chain_r) == cfg_parity);
`else
  assign parity_ok_s = 1'b1;
`endif

  // Commit wins over shift; the shift is suppressed on any commit cycle, accepted or not.
  assign shift_s      = ccff_en & ~cfg_commit;
  assign commit_ok_s  = cfg_commit & full_s & parity_ok_s;
  assign commit_bad_s = cfg_commit & ~commit_ok_s;

  // Next-state for the config chain, active selects, bit counter and status flags.
  always_comb begin
    chain_nxt_s   = chain_r;
    active_nxt_s  = active_r;
    bit_cnt_nxt_s = bit_cnt_r;
    ack_nxt_s     = 1'b0;
    err_nxt_s     = err_r;
    if (commit_ok_s) begin
      active_nxt_s  = chain_r;
      bit_cnt_nxt_s = '0;
      ack_nxt_s     = 1'b1;
    end else if (commit_bad_s) begin
      err_nxt_s = 1'b1;
    end else if (shift_s) begin
      chain_nxt_s   = {chain_r[CHAIN_LEN-2:0], ccff_head};
      bit_cnt_nxt_s = full_s ? bit_cnt_r : (bit_cnt_r + CNT_ONE);
    end else begin
      chain_nxt_s = chain_r;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      chain_r   <= '0;
      active_r  <= '0;
      bit_cnt_r <= '0;
      ack_r     <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      chain_r   <= chain_nxt_s;
      active_r  <= active_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      ack_r     <= ack_nxt_s;
      err_r     <= err_nxt_s;
    end
  end

  assign ccff_tail = chain_r[CHAIN_LEN-1];
  assign cfg_full  = full_s;
  assign cfg_ack   = ack_r;
  assign cfg_err   = err_r;

  // Input j of pin k: pair m=j/2 taps track (k + m*STRIDE) mod CHAN_W, even=left, odd=right.
  for (genvar gk = 0; gk < NUM_IPIN; gk++) begin : g_pin
    for (genvar gj = 0; gj < MUX_SIZE; gj++) begin : g_in
      localparam int TRK = (gk + (gj / 2) * STRIDE) % CHAN_W;
      if ((gj % 2) == 0) begin : g_left
        assign mux_in_s[gk][gj] = chanx_left_in[TRK];
      end else begin : g_right
        assign mux_in_s[gk][gj] = chanx_right_in[TRK];
      end
    end
  end

  // One-hot AND-OR mux; a select at or beyond MUX_SIZE matches no input and yields 0.
  always_comb begin
    pin_s = '0;
    for (int k = 0; k < NUM_IPIN; k++) begin
      for (int j = 0; j < MUX_SIZE; j++) begin
        pin_s[k] = pin_s[k] |
                   ((active_r[k*SEL_W +: SEL_W] == SEL_W'(j)) & mux_in_s[k][j]);
      end
    end
  end

  assign bottom_grid_pin = pin_s;

endmodule

// File: tb/tb_cbx_param_cfg.sv
// Directed self-checking bench for cbx_param_cfg (default parameters).
module tb_cbx_param_cfg;

  logic        prog_clk;
  logic        prog_reset;
  logic [19:0] chanx_left_in, chanx_right_in;
  logic [19:0] chanx_left_out, chanx_right_out;
  logic [5:0]  bottom_grid_pin;
  logic        ccff_head, ccff_en, cfg_commit;
  logic        ccff_tail, cfg_full, cfg_ack, cfg_err;
`ifdef CB_CFG_PARITY_EN
  logic        cfg_parity;
`endif

  int tests = 0;
  int fails = 0;

  cbx_param_cfg dut (
    .prog_clk        (prog_clk),
    .prog_reset      (prog_reset),
    .chanx_left_in   (chanx_left_in),
    .chanx_right_in  (chanx_right_in),
    .chanx_left_out  (chanx_left_out),
    .chanx_right_out (chanx_right_out),
    .bottom_grid_pin (bottom_grid_pin),
    .ccff_head       (ccff_head),
    .ccff_en         (ccff_en),
    .cfg_commit      (cfg_commit),
    .ccff_tail       (ccff_tail),
    .cfg_full        (cfg_full),
    .cfg_ack         (cfg_ack),
    .cfg_err         (cfg_err)
`ifdef CB_CFG_PARITY_EN
    ,
    .cfg_parity      (cfg_parity)
`endif
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    ccff_head = b;
    ccff_en   = 1'b1;
    tick();
    ccff_en   = 1'b0;
  endtask

  // MSB first, so after 24 shifts chain == w and sel[k] == w[4k +: 4].
  task automatic shift_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) shift_bit(w[i]);
  endtask

  task automatic pulse_commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  // Reset asserted together with shift and commit, which it must override.
  task automatic apply_reset();
    prog_reset = 1'b1;
    ccff_en    = 1'b1;
    cfg_commit = 1'b1;
    ccff_head  = 1'b1;
    tick();
    tick();
    prog_reset = 1'b0;
    ccff_en    = 1'b0;
    cfg_commit = 1'b0;
    ccff_head  = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    chanx_left_in  = 20'h00001;
    chanx_right_in = 20'h00000;
    #1;
    tests++; if (bottom_grid_pin !== 6'b000001) begin fails++; $display("FAIL reset_pins: got %b expected %b", bottom_grid_pin, 6'b000001); end
    tests++; if (cfg_full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b expected 0", cfg_full); end
    tests++; if (cfg_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", cfg_err); end
    tests++; if (ccff_tail !== 1'b0) begin fails++; $display("FAIL reset_tail: got %b expected 0", ccff_tail); end
    tests++; if (cfg_ack !== 1'b0) begin fails++; $display("FAIL reset_ack: got %b expected 0", cfg_ack); end
    chanx_left_in = 20'h0002A;
    #1;
    tests++; if (bottom_grid_pin !== 6'b101010) begin fails++; $display("FAIL reset_pins2: got %b expected %b", bottom_grid_pin, 6'b101010); end
    chanx_left_in  = 20'hABCDE;
    chanx_right_in = 20'h12345;
    #1;
    tests++; if (chanx_left_out !== 20'h12345) begin fails++; $display("FAIL feed_left_out: got %h expected 12345", chanx_left_out); end
    tests++; if (chanx_right_out !== 20'hABCDE) begin fails++; $display("FAIL feed_right_out: got %h expected abcde", chanx_right_out); end
    // Partial chain discarded by reset: 10 + 14 shifts must not read as full.
    for (int i = 0; i < 10; i++) shift_bit(1'b1);
    apply_reset();
    tests++; if (ccff_tail !== 1'b0) begin fails++; $display("FAIL midshift_tail: got %b expected 0", ccff_tail); end
    for (int i = 0; i < 14; i++) shift_bit(1'b0);
    tests++; if (cfg_full !== 1'b0) begin fails++; $display("FAIL midshift_full: got %b expected 0", cfg_full); end
  endtask

  task automatic test_full_load();
    apply_reset();
    shift_word(24'h000005);
    tests++; if (cfg_full !== 1'b1) begin fails++; $display("FAIL load_full: got %b expected 1", cfg_full); end
    pulse_commit();
    tests++; if (cfg_ack !== 1'b1) begin fails++; $display("FAIL load_ack: got %b expected 1", cfg_ack); end
    tests++; if (cfg_full !== 1'b0) begin fails++; $display("FAIL load_full_clr: got %b expected 0", cfg_full); end
    tick();
    tests++; if (cfg_ack !== 1'b0) begin fails++; $display("FAIL load_ack_pulse: got %b expected 0", cfg_ack); end
    chanx_left_in  = 20'h00000;
    chanx_right_in = 20'h00040;
    #1;
    tests++; if (bottom_grid_pin !== 6'b000001) begin fails++; $display("FAIL load_pin0: got %b expected %b", bottom_grid_pin, 6'b000001); end
    chanx_right_in = 20'h00000;
    #1;
    tests++; if (bottom_grid_pin !== 6'b000000) begin fails++; $display("FAIL load_toggle0: got %b expected %b", bottom_grid_pin, 6'b000000); end
    chanx_right_in = 20'h00040;
    #1;
    tests++; if (bottom_grid_pin !== 6'b000001) begin fails++; $display("FAIL load_toggle1: got %b expected %b", bottom_grid_pin, 6'b000001); end
    chanx_left_in  = 20'h0003F;
    chanx_right_in = 20'h00000;
    #1;
    tests++; if (bottom_grid_pin !== 6'b111110) begin fails++; $display("FAIL load_others: got %b expected %b", bottom_grid_pin, 6'b111110); end
  endtask

  task automatic test_premature();
    apply_reset();
    shift_word(24'h000005);
    pulse_commit();
    for (int i = 0; i < 10; i++) shift_bit(1'b1);
    pulse_commit();
    tests++; if (cfg_ack !== 1'b0) begin fails++; $display("FAIL early_ack: got %b expected 0", cfg_ack); end
    tests++; if (cfg_err !== 1'b1) begin fails++; $display("FAIL early_err: got %b expected 1", cfg_err); end
    chanx_left_in  = 20'h00000;
    chanx_right_in = 20'h00040;
    tick();
    tick();
    tests++; if (bottom_grid_pin !== 6'b000001) begin fails++; $display("FAIL early_active: got %b expected %b", bottom_grid_pin, 6'b000001); end
    tests++; if (cfg_err !== 1'b1) begin fails++; $display("FAIL early_sticky: got %b expected 1", cfg_err); end
    tests++; if (cfg_full !== 1'b0) begin fails++; $display("FAIL early_full: got %b expected 0", cfg_full); end
    for (int i = 0; i < 14; i++) shift_bit(1'b0);
    tests++; if (cfg_full !== 1'b1) begin fails++; $display("FAIL early_cnt_kept: got %b expected 1", cfg_full); end
    pulse_commit();
    tests++; if (cfg_ack !== 1'b1) begin fails++; $display("FAIL early_retry_ack: got %b expected 1", cfg_ack); end
    tests++; if (cfg_err !== 1'b1) begin fails++; $display("FAIL early_err_hold: got %b expected 1", cfg_err); end
    apply_reset();
    tests++; if (cfg_err !== 1'b0) begin fails++; $display("FAIL early_err_reset: got %b expected 0", cfg_err); end
  endtask

  // sel = {8, 9, 3, C, 2, 1}: pin0<-R[0], pin1<-L[4], pin2 invalid, pin3<-R[6], pin4<-R[16], pin5<-L[17].
  task automatic test_invalid_sel();
    apply_reset();
    shift_word(24'h893C21);
    pulse_commit();
    tests++; if (cfg_ack !== 1'b1) begin fails++; $display("FAIL inv_ack: got %b expected 1", cfg_ack); end
    chanx_left_in  = 20'hFFFFF;
    chanx_right_in = 20'hFFFFF;
    #1;
    tests++; if (bottom_grid_pin !== 6'b111011) begin fails++; $display("FAIL inv_ones: got %b expected %b", bottom_grid_pin, 6'b111011); end
    chanx_left_in  = 20'h00010;
    chanx_right_in = 20'h10000;
    #1;
    tests++; if (bottom_grid_pin !== 6'b010010) begin fails++; $display("FAIL inv_vec1: got %b expected %b", bottom_grid_pin, 6'b010010); end
    chanx_left_in  = 20'h20000;
    chanx_right_in = 20'h00041;
    #1;
    tests++; if (bottom_grid_pin !== 6'b101001) begin fails++; $display("FAIL inv_vec2: got %b expected %b", bottom_grid_pin, 6'b101001); end
    chanx_left_in  = 20'h00000;
    chanx_right_in = 20'h00000;
    #1;
    tests++; if (bottom_grid_pin !== 6'b000000) begin fails++; $display("FAIL inv_zero: got %b expected %b", bottom_grid_pin, 6'b000000); end
  endtask

  task automatic test_passthrough();
    logic [23:0] p;
    logic [23:0] q;
    logic        exp;
    p = 24'hA5C39E;
    q = 24'h800005;
    apply_reset();
    shift_word(p);
    tests++; if (ccff_tail !== p[23]) begin fails++; $display("FAIL pass_tail24: got %b expected %b", ccff_tail, p[23]); end
    for (int i = 23; i >= 0; i--) begin
      shift_bit(q[i]);
      exp = (i > 0) ? p[i-1] : q[23];
      tests++; if (ccff_tail !== exp) begin fails++; $display("FAIL pass_tail i=%0d: got %b expected %b", i, ccff_tail, exp); end
    end
    tests++; if (cfg_full !== 1'b1) begin fails++; $display("FAIL pass_full_sat: got %b expected 1", cfg_full); end
    // Simultaneous shift+commit: commit taken, shift dropped, tail stays q[23].
    ccff_head  = 1'b1;
    ccff_en    = 1'b1;
    cfg_commit = 1'b1;
    tick();
    ccff_en    = 1'b0;
    cfg_commit = 1'b0;
    tests++; if (cfg_ack !== 1'b1) begin fails++; $display("FAIL simul_ack: got %b expected 1", cfg_ack); end
    tests++; if (cfg_full !== 1'b0) begin fails++; $display("FAIL simul_full: got %b expected 0", cfg_full); end
    tests++; if (ccff_tail !== 1'b1) begin fails++; $display("FAIL simul_noshift: got %b expected 1", ccff_tail); end
    chanx_left_in  = 20'h20000;
    chanx_right_in = 20'h00040;
    #1;
    tests++; if (bottom_grid_pin !== 6'b100001) begin fails++; $display("FAIL simul_active: got %b expected %b", bottom_grid_pin, 6'b100001); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    shift_word(24'h000005);
    pulse_commit();
    tests++; if (cfg_ack !== 1'b1) begin fails++; $display("FAIL b2b_first_ack: got %b expected 1", cfg_ack); end
    pulse_commit();
    tests++; if (cfg_ack !== 1'b0) begin fails++; $display("FAIL b2b_second_ack: got %b expected 0", cfg_ack); end
    tests++; if (cfg_err !== 1'b1) begin fails++; $display("FAIL b2b_err: got %b expected 1", cfg_err); end
  endtask

`ifdef CB_CFG_PARITY_EN
  task automatic test_parity();
    apply_reset();
    shift_word(24'h000001);
    cfg_parity = 1'b0;
    pulse_commit();
    tests++; if (cfg_ack !== 1'b0) begin fails++; $display("FAIL par_bad_ack: got %b expected 0", cfg_ack); end
    tests++; if (cfg_err !== 1'b1) begin fails++; $display("FAIL par_bad_err: got %b expected 1", cfg_err); end
    tests++; if (cfg_full !== 1'b1) begin fails++; $display("FAIL par_cnt_kept: got %b expected 1", cfg_full); end
    chanx_left_in  = 20'h00000;
    chanx_right_in = 20'h00001;
    #1;
    tests++; if (bottom_grid_pin !== 6'b000000) begin fails++; $display("FAIL par_active_hold: got %b expected %b", bottom_grid_pin, 6'b000000); end
    cfg_parity = 1'b1;
    pulse_commit();
    tests++; if (cfg_ack !== 1'b1) begin fails++; $display("FAIL par_retry_ack: got %b expected 1", cfg_ack); end
    tests++; if (bottom_grid_pin !== 6'b000001) begin fails++; $display("FAIL par_retry_active: got %b expected %b", bottom_grid_pin, 6'b000001); end
  endtask
`endif

  initial begin
    prog_reset     = 1'b1;
    chanx_left_in  = 20'h00000;
    chanx_right_in = 20'h00000;
    ccff_head      = 1'b0;
    ccff_en        = 1'b0;
    cfg_commit     = 1'b0;
`ifdef CB_CFG_PARITY_EN
    cfg_parity     = 1'b0;
`endif
    test_reset();
    test_full_load();
    test_premature();
    test_invalid_sel();
    test_passthrough();
    test_back_to_back();
`ifdef CB_CFG_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
